// File: rtl/alu_pkg.sv
// Shared opcode and width definitions for the alu execute unit.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int RES_W  = 16;

   typedef enum logic [3:0] {
      OP_ADD     = 4'd0,
      OP_SUB     = 4'd1,
      OP_MUL     = 4'd2,
      OP_AND     = 4'd3,
      OP_OR      = 4'd4,
      OP_NOT     = 4'd5,
      OP_XOR     = 4'd6,
      OP_XNOR    = 4'd7,
      OP_LSHIFT  = 4'd8,
      OP_RSHIFT  = 4'd9,
      OP_L_AND   = 4'd10,
      OP_L_OR    = 4'd11,
      OP_L_NOT   = 4'd12,
      OP_EQUAL   = 4'd13,
      OP_GREATER = 4'd14,
      OP_LESSER  = 4'd15
   } op_e;

   function automatic logic [RES_W-1:0] bool_res(input logic bit_val);
      return {{(RES_W-1){1'b0}}, bit_val};
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle for the alu; zero/carry exist only when ALU_FLAGS_EN is defined.
interface alu_if;
   import alu_pkg::*;

   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [3:0]        sel;
   logic              in_valid;
   logic [RES_W-1:0]  y;
   logic              out_valid;
`ifdef ALU_FLAGS_EN
   logic              zero;
   logic              carry;

   modport master (output a, b, sel, in_valid, input y, out_valid, zero, carry);
   modport slave  (input a, b, sel, in_valid, output y, out_valid, zero, carry);
`else
   modport master (output a, b, sel, in_valid, input y, out_valid);
   modport slave  (input a, b, sel, in_valid, output y, out_valid);
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational datapath of the alu: 16 operations on zero-extended unsigned operands.
module alu_core
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        sel,
   output logic [RES_W-1:0]  res,
   output logic              carry
);

   logic [RES_W-1:0] a_ext;
   logic [RES_W-1:0] b_ext;
   op_e              op;

   assign a_ext = {{(RES_W-DATA_W){1'b0}}, a};
   assign b_ext = {{(RES_W-DATA_W){1'b0}}, b};
   assign op    = op_e'(sel);

   always_comb begin
      res   = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: begin
            res   = a_ext + b_ext;
            carry = res[DATA_W];
         end
         OP_SUB: begin
            res   = a_ext - b_ext;
            carry = (a < b);
         end
         OP_MUL:     res = a_ext * b_ext;
         OP_AND:     res = a_ext & b_ext;
         OP_OR:      res = a_ext | b_ext;
         OP_NOT:     res = {{(RES_W-DATA_W){1'b0}}, ~a};
         OP_XOR:     res = a_ext ^ b_ext;
         OP_XNOR:    res = {{(RES_W-DATA_W){1'b0}}, ~(a ^ b)};
         // Shift counts past the word width naturally produce zero.
         OP_LSHIFT:  res = a_ext << b;
         OP_RSHIFT:  res = a_ext >> b;
         OP_L_AND:   res = bool_res((a != '0) && (b != '0));
         OP_L_OR:    res = bool_res((a != '0) || (b != '0));
         OP_L_NOT:   res = bool_res(a == '0);
         OP_EQUAL:   res = bool_res(a == b);
         OP_GREATER: res = bool_res(a > b);
         OP_LESSER:  res = bool_res(a < b);
         default: begin
            res   = '0;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// General-purpose execute unit: registered alu_core result with one-cycle valid.
// Define ALU_FLAGS_EN to add the registered zero and carry flags.
module alu
   import alu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   alu_if.slave bus
);

   logic [RES_W-1:0] res;
   logic [RES_W-1:0] y_q;
   logic             out_valid_q;

`ifdef ALU_FLAGS_EN
   logic             carry_raw;
   logic             zero_q;
   logic             carry_q;
`else
   logic             carry_unused;
`endif

   alu_core u_core (
      .a     (bus.a),
      .b     (bus.b),
      .sel   (bus.sel),
      .res   (res),
`ifdef ALU_FLAGS_EN
      .carry (carry_raw)
`else
      .carry (carry_unused)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.in_valid) begin
         y_q         <= res;
         out_valid_q <= 1'b1;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (bus.in_valid) begin
         zero_q  <= (res == '0);
         carry_q <= carry_raw;
      end
   end

   assign bus.zero  = zero_q;
   assign bus.carry = carry_q;
`endif

   assign bus.y         = y_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu; flag checks apply when built with ALU_FLAGS_EN.
module tb_alu;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   alu_if bus ();

   alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic exp_zero, input logic exp_carry);
`ifdef ALU_FLAGS_EN
      chk({tag, ".zero"},  {15'b0, bus.zero},  {15'b0, exp_zero});
      chk({tag, ".carry"}, {15'b0, bus.carry}, {15'b0, exp_carry});
`endif
   endtask

   task automatic step(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] ts,
                       input logic tv);
      bus.a        = ta;
      bus.b        = tb_v;
      bus.sel      = ts;
      bus.in_valid = tv;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] sweep_exp [16] = '{16'd18, 16'd12, 16'd45, 16'd3,
                                   16'd15, 16'h00F0, 16'd12, 16'h00F3,
                                   16'd120, 16'd1, 16'd1, 16'd1,
                                   16'd0, 16'd0, 16'd1, 16'd0};

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      bus.a        = 8'd15;
      bus.b        = 8'd3;
      bus.sel      = 4'd2;
      bus.in_valid = 1'b1;

      // reset wins over a pending MUL
      for (int i = 0; i < 2; i++) begin
         step(8'd15, 8'd3, 4'd2, 1'b1);
         chk("rst.y", bus.y, 16'h0000);
         chk("rst.out_valid", {15'b0, bus.out_valid}, 16'd0);
         chk_flags("rst", 1'b0, 1'b0);
      end
      rst = 1'b0;
      step(8'd15, 8'd3, 4'd2, 1'b1);
      chk("post_rst.y", bus.y, 16'd45);
      chk("post_rst.out_valid", {15'b0, bus.out_valid}, 16'd1);

      for (int s = 0; s < 16; s++) begin
         step(8'd15, 8'd3, 4'(s), 1'b1);
         chk($sformatf("sweep%0d.y", s), bus.y, sweep_exp[s]);
         chk($sformatf("sweep%0d.out_valid", s), {15'b0, bus.out_valid}, 16'd1);
         chk_flags($sformatf("sweep%0d", s), sweep_exp[s] == 16'd0, 1'b0);
      end

      step(8'd3, 8'd15, OP_SUB, 1'b1);
      chk("sub_borrow.y", bus.y, 16'hFFF4);
      chk_flags("sub_borrow", 1'b0, 1'b1);
      step(8'd255, 8'd255, OP_ADD, 1'b1);
      chk("add_max.y", bus.y, 16'd510);
      chk_flags("add_max", 1'b0, 1'b1);
      step(8'd255, 8'd255, OP_MUL, 1'b1);
      chk("mul_max.y", bus.y, 16'd65025);
      chk_flags("mul_max", 1'b0, 1'b0);
      step(8'd0, 8'd7, OP_L_NOT, 1'b1);
      chk("lnot_zero.y", bus.y, 16'd1);
      step(8'd0, 8'd0, OP_L_OR, 1'b1);
      chk("lor_zero.y", bus.y, 16'd0);
      chk_flags("lor_zero", 1'b1, 1'b0);
      step(8'd5, 8'd5, OP_SUB, 1'b1);
      chk("sub_equal.y", bus.y, 16'd0);
      chk_flags("sub_equal", 1'b1, 1'b0);

      step(8'h81, 8'd8, OP_LSHIFT, 1'b1);
      chk("lsh8.y", bus.y, 16'h8100);
      step(8'hFF, 8'd15, OP_LSHIFT, 1'b1);
      chk("lsh15.y", bus.y, 16'h8000);
      step(8'h81, 8'd16, OP_LSHIFT, 1'b1);
      chk("lsh16.y", bus.y, 16'h0000);
      step(8'h80, 8'd7, OP_RSHIFT, 1'b1);
      chk("rsh7.y", bus.y, 16'd1);
      step(8'h80, 8'd8, OP_RSHIFT, 1'b1);
      chk("rsh8.y", bus.y, 16'd0);

      // hold: y and flags keep the last loaded result while in_valid is low
      step(8'd3, 8'd15, OP_SUB, 1'b1);
      chk("hold_load.y", bus.y, 16'hFFF4);
      for (int i = 0; i < 3; i++) begin
         step(8'(i), 8'd9, OP_ADD, 1'b0);
         chk("hold_borrow.y", bus.y, 16'hFFF4);
         chk("hold_borrow.out_valid", {15'b0, bus.out_valid}, 16'd0);
         chk_flags("hold_borrow", 1'b0, 1'b1);
      end
      step(8'd15, 8'd3, OP_ADD, 1'b1);
      chk("hold_add.y", bus.y, 16'd18);
      for (int i = 0; i < 3; i++) begin
         step(8'd1, 8'd1, OP_SUB, 1'b0);
         chk("hold.y", bus.y, 16'd18);
         chk("hold.out_valid", {15'b0, bus.out_valid}, 16'd0);
      end
      step(8'd1, 8'd1, OP_SUB, 1'b1);
      chk("resume.y", bus.y, 16'd0);
      chk("resume.out_valid", {15'b0, bus.out_valid}, 16'd1);
      chk_flags("resume", 1'b1, 1'b0);

      step(8'd7, 8'd2, OP_XOR, 1'b1);
      chk("b2b_a.y", bus.y, 16'd5);
      step(8'd200, 8'd100, OP_GREATER, 1'b1);
      chk("b2b_b.y", bus.y, 16'd1);
      step(8'd100, 8'd200, OP_LESSER, 1'b1);
      chk("b2b_c.y", bus.y, 16'd1);

      rst = 1'b1;
      step(8'd255, 8'd255, OP_MUL, 1'b1);
      chk("mid_rst.y", bus.y, 16'h0000);
      chk("mid_rst.out_valid", {15'b0, bus.out_valid}, 16'd0);
      rst = 1'b0;
      step(8'd0, 8'd0, OP_ADD, 1'b0);
      chk("idle_after_rst.out_valid", {15'b0, bus.out_valid}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
